// File: rtl/cfu_pkg.sv
// Shared constants and types for the matrix unit: geometry, memory map,
// opcodes and the write-back serializer state.
package cfu_pkg;

    localparam int          N       = 16;
    localparam int          LogN    = $clog2(N);
    localparam logic [31:0] ADDR    = 32'h0000_0000;
    localparam int          B_START = 256;
    localparam int          C_START = 512;

    localparam logic [7:0] OP_LDB    = 8'b0000_1001;
    localparam logic [7:0] OP_LDA    = 8'b0000_1010;
    localparam logic [7:0] OP_MATMUL = 8'b0000_0011;
    localparam logic [7:0] OP_WB     = 8'b0000_0100;
    localparam logic [7:0] OP_END    = 8'b1000_0000;

    typedef logic [N-1:0][31:0] row_t;

    typedef enum logic {
        WB_IDLE,
        WB_WRITE
    } wb_state_e;

    // First C-region word address of a result row.
    function automatic logic [31:0] c_row_addr(input logic [31:0] base,
                                               input int          c_start,
                                               input logic [31:0] row,
                                               input int          n);
        return base + 32'(c_start) + row * 32'(n);
    endfunction

endpackage

// File: rtl/cfu_row_fifo.sv
// Two-entry FIFO holding completed result rows ahead of the word serializer.
module cfu_row_fifo #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_q;
    logic         rd_q;
    logic [1:0]   cnt_q;
    logic [1:0]   cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (push_i && !pop_i) begin
            cnt_d = cnt_q + 2'd1;
        end else if (pop_i && !push_i) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (push_i) wr_q <= ~wr_q;
            if (pop_i)  rd_q <= ~rd_q;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: an entry is only read after being written.
    always_ff @(posedge clk_i) begin
        if (push_i && !rst_i) begin
            mem_q[wr_q] <= din_i;
        end
    end

    assign dout_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/cfu_wb_drain.sv
// Result write-back drain: buffers up to two N-lane result rows and streams
// them out as single-word writes into the C region of data memory.
module cfu_wb_drain #(
    parameter int          N       = cfu_pkg::N,
    parameter int          LogN    = $clog2(N),
    parameter logic [31:0] ADDR    = cfu_pkg::ADDR,
    parameter int          C_START = cfu_pkg::C_START
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic                 WB_VALID,
    input  logic [LogN-1:0]      WB_ROW,
    input  logic [N-1:0][31:0]   RESULT,
    output logic                 WB_READY,
    output logic                 MEM_WE,
    output logic [31:0]          MEM_ADDR,
    output logic [31:0]          MEM_WDATA,
    input  logic                 MEM_ACK,
    output logic                 BUSY,
    output logic                 MAT_DONE
);

    import cfu_pkg::*;

    localparam int EW = LogN + N*32;
    localparam logic [LogN-1:0] LAST = LogN'(N-1);

    logic [1:0]          cnt;
    logic                push;
    logic                pop;
    logic                last_ack;
    logic [EW-1:0]       head;
    logic [LogN-1:0]     head_row;
    logic [N-1:0][31:0]  head_data;

    wb_state_e           state_q;
    logic [LogN-1:0]     row_q;
    logic [LogN-1:0]     lane_q;
    logic [LogN-1:0]     lane_nx;
    logic [N-1:0][31:0]  data_q;
    logic [31:0]         addr_q;
    logic [31:0]         wdata_q;
    logic                done_q;

    cfu_row_fifo #(
        .W (EW)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RSTN),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   ({WB_ROW, RESULT}),
        .dout_o  (head),
        .count_o (cnt)
    );

    assign head_row  = head[EW-1 -: LogN];
    assign head_data = head[N*32-1:0];

    // Ready looks only at the registered occupancy (and reset), never at WB_VALID.
    assign WB_READY = !RSTN && (cnt != 2'd2);
    assign push     = WB_VALID && WB_READY;
    assign last_ack = (state_q == WB_WRITE) && MEM_ACK && (lane_q == LAST);
    // Popping on the last ack of a row keeps back-to-back rows bubble-free.
    assign pop      = (cnt != 2'd0) && ((state_q == WB_IDLE) || last_ack);
    assign lane_nx  = lane_q + LogN'(1);

    always_ff @(posedge CLK) begin
        if (RSTN) begin
            state_q <= WB_IDLE;
            row_q   <= '0;
            lane_q  <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                WB_IDLE: begin
                    if (pop) begin
                        state_q <= WB_WRITE;
                        row_q   <= head_row;
                        data_q  <= head_data;
                        lane_q  <= '0;
                        addr_q  <= c_row_addr(ADDR, C_START, 32'(head_row), N);
                        wdata_q <= head_data[0];
                    end
                end
                WB_WRITE: begin
                    if (MEM_ACK) begin
                        if (lane_q != LAST) begin
                            lane_q  <= lane_nx;
                            addr_q  <= addr_q + 32'd1;
                            wdata_q <= data_q[lane_nx];
                        end else begin
                            done_q <= (row_q == LAST);
                            if (pop) begin
                                row_q   <= head_row;
                                data_q  <= head_data;
                                lane_q  <= '0;
                                addr_q  <= c_row_addr(ADDR, C_START, 32'(head_row), N);
                                wdata_q <= head_data[0];
                            end else begin
                                state_q <= WB_IDLE;
                            end
                        end
                    end
                end
                default: state_q <= WB_IDLE;
            endcase
        end
    end

    assign MEM_WE    = (state_q == WB_WRITE);
    assign MEM_ADDR  = addr_q;
    assign MEM_WDATA = wdata_q;
    assign MAT_DONE  = done_q;
    assign BUSY      = (cnt != 2'd0) || (state_q == WB_WRITE);

endmodule

// File: tb/tb_cfu_wb_drain.sv
// Directed/randomised bench for cfu_wb_drain: every accepted row expands into
// an expected list of (address, data) writes that the memory side must match.
module tb_cfu_wb_drain;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic               CLK = 1'b0;
    logic               RSTN = 1'b1;
    logic               WB_VALID = 1'b1;
    logic [3:0]         WB_ROW = '0;
    logic [15:0][31:0]  RESULT = '0;
    logic               MEM_ACK = 1'b0;
    logic               WB_READY, MEM_WE, BUSY, MAT_DONE;
    logic [31:0]        MEM_ADDR, MEM_WDATA;

    cfu_wb_drain dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .WB_VALID  (WB_VALID),
        .WB_ROW    (WB_ROW),
        .RESULT    (RESULT),
        .WB_READY  (WB_READY),
        .MEM_WE    (MEM_WE),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_WDATA (MEM_WDATA),
        .MEM_ACK   (MEM_ACK),
        .BUSY      (BUSY),
        .MAT_DONE  (MAT_DONE)
    );

    always #5 CLK = ~CLK;

    int          ncmp = 0;
    int          nfail = 0;
    int          ack_mode = 1;   // 0 never, 1 always, 2 toggle, 3 random
    int          cyc = 0;
    int          nwr = 0;
    int          ndone = 0;
    int          first_wr = -1;
    int          last_wr = -1;
    logic        exp_done = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_a = '0;
    logic [31:0] prev_d = '0;
    wr_t         exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // A row lands at C base 512 + row*16, one word per lane, lane 0 first.
    task automatic push_row(input logic [3:0] row, input logic [15:0][31:0] data);
        for (int l = 0; l < 16; l++) begin
            exp_q.push_back('{a: 32'd512 + 32'(row) * 32'd16 + 32'(l), d: data[l]});
        end
    endtask

    // One clock: drive ACK, check this cycle's outputs, then advance to the next negedge.
    task automatic step();
        wr_t e;
        case (ack_mode)
            0:       MEM_ACK = 1'b0;
            1:       MEM_ACK = 1'b1;
            2:       MEM_ACK = cyc[0];
            default: MEM_ACK = 1'($urandom_range(0, 1));
        endcase
        chk("mat_done", 32'(MAT_DONE), 32'(exp_done));
        if (MAT_DONE === 1'b1) ndone++;
        exp_done = 1'b0;
        if (prev_stall && !RSTN) begin
            chk("stall_we", 32'(MEM_WE), 32'd1);
            chk("stall_addr", MEM_ADDR, prev_a);
            chk("stall_data", MEM_WDATA, prev_d);
        end
        if (MEM_WE === 1'b1 && MEM_ACK && !RSTN) begin
            ncmp++;
            assert (exp_q.size() != 0) else begin
                nfail++;
                $error("FAIL unexpected_write: observed write to %0h expected none", MEM_ADDR);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("wr_addr", MEM_ADDR, e.a);
                chk("wr_data", MEM_WDATA, e.d);
                if (e.a == 32'd767) exp_done = 1'b1;
            end
            nwr++;
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
        end
        prev_stall = (MEM_WE === 1'b1) && !MEM_ACK && !RSTN;
        prev_a = MEM_ADDR;
        prev_d = MEM_WDATA;
        if (WB_VALID && WB_READY === 1'b1 && !RSTN) push_row(WB_ROW, RESULT);
        @(posedge CLK);
        @(negedge CLK);
        cyc++;
    endtask

    task automatic offer(input logic [3:0] row, input logic [15:0][31:0] data);
        logic ok;
        ok = 1'b0;
        WB_VALID = 1'b1;
        WB_ROW = row;
        RESULT = data;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (WB_READY === 1'b1) ok = 1'b1;
            step();
        end
        WB_VALID = 1'b0;
        chk("offer_accepted", 32'(ok), 32'd1);
    endtask

    task automatic drain();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            if (BUSY === 1'b0 && MEM_WE === 1'b0 && exp_q.size() == 0) ok = 1'b1;
            else step();
        end
        chk("drain_done", 32'(ok), 32'd1);
    endtask

    initial begin
        logic [15:0][31:0] d, d2;
        int tbl [16] = '{146, 165, 154, 143, 122, 121, 130, 90, 89, 78, 67, 65, 45, 34, 23, 13};
        int nwr0, nd0, c0;
        logic hit;

        // Reset held two cycles with a row offered.
        @(posedge CLK); @(negedge CLK);
        @(posedge CLK); @(negedge CLK);
        chk("rst_ready", 32'(WB_READY), 32'd0);
        chk("rst_we", 32'(MEM_WE), 32'd0);
        chk("rst_addr", MEM_ADDR, 32'd0);
        chk("rst_wdata", MEM_WDATA, 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(MAT_DONE), 32'd0);
        RSTN = 1'b0;
        WB_VALID = 1'b0;
        step();
        chk("ready_after_rst", 32'(WB_READY), 32'd1);
        chk("idle_busy", 32'(BUSY), 32'd0);

        // Single row 3, always-ack.
        ack_mode = 1;
        for (int l = 0; l < 16; l++) d[l] = 32'(tbl[l]);
        nwr0 = nwr;
        first_wr = -1;
        offer(4'd3, d);
        chk("lat_we_k", 32'(MEM_WE), 32'd0);
        step();
        chk("lat_we_k1", 32'(MEM_WE), 32'd1);
        drain();
        chk("single_nwr", 32'(nwr - nwr0), 32'd16);
        chk("single_span", 32'(last_wr - first_wr + 1), 32'd16);
        chk("single_we_end", 32'(MEM_WE), 32'd0);
        chk("single_busy_end", 32'(BUSY), 32'd0);

        // Backpressure: toggling ack, three rows offered back to back.
        ack_mode = 2;
        nwr0 = nwr;
        c0 = cyc;
        for (int r = 0; r < 3; r++) begin
            for (int l = 0; l < 16; l++) d[l] = $urandom();
            offer(4'(r), d);
        end
        chk("bp_back_to_back", 32'(cyc - c0), 32'd3);
        chk("bp_ready_low", 32'(WB_READY), 32'd0);
        chk("bp_busy", 32'(BUSY), 32'd1);
        drain();
        chk("bp_nwr", 32'(nwr - nwr0), 32'd48);

        // Full matrix, all lanes 23, always-ack: no bubbles, one MAT_DONE.
        ack_mode = 1;
        nwr0 = nwr;
        nd0 = ndone;
        first_wr = -1;
        for (int l = 0; l < 16; l++) d[l] = 32'd23;
        for (int r = 0; r < 16; r++) offer(4'(r), d);
        drain();
        step();
        chk("full_nwr", 32'(nwr - nwr0), 32'd256);
        chk("full_span", 32'(last_wr - first_wr + 1), 32'd256);
        chk("full_done_pulses", 32'(ndone - nd0), 32'd1);

        // Row 15 twice with random ack: two MAT_DONE pulses, same addresses.
        ack_mode = 3;
        nwr0 = nwr;
        nd0 = ndone;
        for (int l = 0; l < 16; l++) begin
            d[l] = $urandom();
            d2[l] = $urandom();
        end
        offer(4'd15, d);
        offer(4'd15, d2);
        drain();
        step();
        chk("rep_nwr", 32'(nwr - nwr0), 32'd32);
        chk("rep_done_pulses", 32'(ndone - nd0), 32'd2);

        // Reset right after lane 5 of row 7 is acked, with row 8 buffered.
        ack_mode = 1;
        nwr0 = nwr;
        for (int l = 0; l < 16; l++) begin
            d[l] = $urandom();
            d2[l] = $urandom();
        end
        offer(4'd7, d);
        offer(4'd8, d2);
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            if (nwr - nwr0 == 6) hit = 1'b1;
            else step();
        end
        chk("mid_lane5_reached", 32'(hit), 32'd1);
        chk("mid_last_addr", prev_a, 32'd512 + 32'd7 * 32'd16 + 32'd5);
        RSTN = 1'b1;
        step();
        exp_q.delete();
        prev_stall = 1'b0;
        chk("mid_rst_we", 32'(MEM_WE), 32'd0);
        chk("mid_rst_busy", 32'(BUSY), 32'd0);
        chk("mid_rst_ready", 32'(WB_READY), 32'd0);
        RSTN = 1'b0;
        nwr0 = nwr;
        for (int i = 0; i < 20; i++) step();
        chk("mid_no_writes", 32'(nwr - nwr0), 32'd0);
        chk("mid_idle_busy", 32'(BUSY), 32'd0);
        chk("mid_idle_ready", 32'(WB_READY), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/cfu_wb_drain.md
# cfu_wb_drain

Result write-back drain for the SIMD matrix unit: it is the write-side counterpart of the fetch path that loads A rows and B columns from memory. It accepts completed N-lane result rows (`RESULT`) from the MAC array during the WriteBack instruction (opcode `8'b00000100`). It buffers up to two rows and serialises each row into single 32-bit word writes to the data memory's C region, signalling when the whole N×N result matrix has been committed.

## Interface
- `N`, 16: lanes per row and rows per matrix.
- `LogN`, `$clog2(N)`: row/lane index width.
- `ADDR`, `32'h00000000`: data memory base word address.
- `C_START`, 512: word offset of the C (result) region; A sits at 0 and B at 256.
- `CLK` input 1: single clock; all logic on its rising edge.
- `RSTN` input 1: reset, synchronous, active-high (asserted = 1 resets the block).
- `WB_VALID` input 1: a result row is offered.
- `WB_ROW` input LogN: row index of the offered row.
- `RESULT` input [N-1:0][31:0]: row data; lane 0 is column 0.
- `WB_READY` output 1: row buffer can accept a row.
- `MEM_WE` output 1: write request.
- `MEM_ADDR` output 32: word address.
- `MEM_WDATA` output 32: write data.
- `MEM_ACK` input 1: memory accepts the current write this cycle.
- `BUSY` output 1: buffer non-empty or a write is outstanding.
- `MAT_DONE` output 1: one-cycle pulse when the last word of row N-1 is acknowledged.

## Operation
- Row buffer: 2-entry FIFO of {row index, N×32 data}.
  - Push when `WB_VALID && WB_READY`.
  - `WB_READY = (count != 2)`, driven from registered count only; it has no combinational path from `WB_VALID`.
- Serializer states are IDLE and WRITE.
- IDLE → WRITE when the FIFO is non-empty: pop the head into the row register and clear lane counter `lane` to 0.
- In WRITE:
  - `MEM_WE = 1`.
  - `MEM_ADDR = ADDR + C_START + row*N + lane`, computed in 32-bit unsigned arithmetic; `row*N` is zero-extended.
  - `MEM_WDATA = row_reg[lane]`.
  - Address and data hold stable while `MEM_ACK = 0`.
- On `MEM_ACK`, when `lane < N-1`: increment `lane`.
- On `MEM_ACK`, when `lane == N-1`:
  - If `row == N-1`, assert `MAT_DONE` on the next cycle.
  - If the FIFO is non-empty, pop the next row on the same edge and stay in WRITE with `lane = 0` (no bubble).
  - Otherwise go to IDLE.
- `MEM_ACK` while in IDLE is ignored.
- Row indices are not checked for order or duplication.
  - A repeated row index is rewritten to the same addresses.
  - `MAT_DONE` depends only on `row == N-1`.
- `BUSY = (count != 0) || (state == WRITE)`.

## Timing
- Reset values, held while `RSTN = 1`:
  - `WB_READY = 0` (outputs 1 from the first cycle after reset deasserts).
  - `MEM_WE = 0`, `MEM_ADDR = 0`, `MEM_WDATA = 0`, `BUSY = 0`, `MAT_DONE = 0`.
  - FIFO empty, state IDLE, `lane = 0`.
- Reset mid-operation discards buffered rows and the in-flight word; no further writes are issued.
- Latency from a row accepted at edge k:
  - It is popped at edge k+1 if the serializer is idle.
  - `MEM_WE` is high from edge k+1 onward.
- Throughput with `MEM_ACK` tied high: one word per cycle and exactly N cycles per row, including back-to-back rows.
- Simultaneous push and pop at count 1: count stays 1.
- Push at count 2 is impossible because `WB_READY = 0`.
- `MAT_DONE` is registered: high exactly one cycle, the cycle after the acknowledging edge.
- `MEM_ADDR` and `MEM_WDATA` are registered outputs.

## Structure
- Shared package `cfu_pkg`:
  - `N`, `LogN`, `ADDR`, `B_START`, `C_START`.
  - Opcode constants: `OP_LDB = 8'b00001001`, `OP_LDA = 8'b00001010`, `OP_MATMUL = 8'b00000011`, `OP_WB = 8'b00000100`, `OP_END = 8'b10000000`.
  - `typedef logic [N-1:0][31:0] row_t`.
  - Serializer state enum `wb_state_e {WB_IDLE, WB_WRITE}`.
- One sub-module, `cfu_row_fifo`: the 2-entry FIFO, parameterised on entry width, exposing `push`/`pop`/`count`.

## Test plan
- Reset: hold `RSTN = 1` for 2 cycles with `WB_VALID = 1` → all outputs 0, no `MEM_WE`; `WB_READY = 1` on the first cycle after release.
- Single row, `MEM_ACK = 1`:
  - Stimulus: `WB_ROW = 3`, `RESULT` lanes 0..15 = {146, 165, 154, 143, 122, 121, 130, 90, 89, 78, 67, 65, 45, 34, 23, 13}.
  - Required: 16 consecutive writes to addresses 560..575 with that data, then `MEM_WE = 0` and `BUSY = 0`.
- Backpressure:
  - Stimulus: `MEM_ACK` toggling 0/1; offer rows 0, 1, 2 back-to-back.
  - Required: `WB_READY` falls after 2 rows are buffered; address/data stable across non-ack cycles; 48 writes to 512..559 in order.
- Full matrix: rows 0..15, all lanes = 23, `ACK = 1` → 256 writes to 512..767, no bubbles; `MAT_DONE` pulses once, the cycle after the ack of address 767.
- Reset mid-row: assert `RSTN` after the ack of lane 5 of row 7 → the next cycle has `MEM_WE = 0`, FIFO empty, and no further writes.
- Repeated row 15: `MAT_DONE` pulses twice, both writes target 752..767.
